// File: rtl/gray_trk_pkg.sv
// Shared types and helpers for the Gray-code position tracker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: default widths, tracker FSM state type, Gray-to-binary conversion.
package gray_trk_pkg;

   localparam int GW_DEF    = 3;
   localparam int PW_DEF    = 16;
   localparam int ERR_W_DEF = 8;

   typedef enum logic {
      S_INIT  = 1'b0,
      S_TRACK = 1'b1
   } trk_state_t;

   // Reflected Gray to binary: bit i of the binary value is the XOR of all
   // Gray bits at position i and above. Bits above w are ignored.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] mask;
      logic [31:0] gm;
      logic [31:0] b;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      gm   = g & mask;
      b    = '0;
      for (int i = 0; i < 32; i++) begin
         b[i] = ^(gm >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// W-wide two-flop synchroniser for a Gray-coded bus from another clock domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports: clk, reset (async, active-high), d (async input bus), q (synchronised bus).
// Only one bit of a Gray bus changes per step, so per-bit synchronisation is safe.
module gray_sync #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gray_pos_tracker.sv
// Converts a sampled Gray-coded up/down count into a signed position with step pulses and error stats.
// Latency: gray_in stable before edge k -> pos/steps at edge k+1 (k+2 with GRAY_TRK_SYNC_EN).
// Backpressure: none; en gates tracking, input sampling always runs.
//
// Ports: clk, reset (async, active-high), en, clr (sync clear + rebaseline), gray_in[GW];
//        pos[PW] (signed, wrapping), step_up/step_dn (1-cycle pulses), dir (1 = up),
//        valid (baseline captured), err (sticky), err_cnt[ERR_W] (saturating).
// Build option: define GRAY_TRK_SYNC_EN to pass gray_in through a 2-flop synchroniser
// (upstream counter on an unrelated clock); otherwise a single capture register is used.
module gray_pos_tracker
   import gray_trk_pkg::*;
#(
   parameter int GW    = GW_DEF,
   parameter int PW    = PW_DEF,
   parameter int ERR_W = ERR_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [GW-1:0]    gray_in,
   output logic [PW-1:0]    pos,
   output logic             step_up,
   output logic             step_dn,
   output logic             dir,
   output logic             valid,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [GW-1:0]    DELTA_UP = GW'(1);
   localparam logic [GW-1:0]    DELTA_DN = '1;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   // ---------------------------------------------------------------- sample
   logic [GW-1:0] gray_s;

`ifdef GRAY_TRK_SYNC_EN
   gray_sync #(.W(GW)) u_gray_sync (
      .clk   (clk),
      .reset (reset),
      .d     (gray_in),
      .q     (gray_s)
   );
`else
   logic [GW-1:0] gray_s_q, gray_s_d;

   always_comb gray_s_d = gray_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) gray_s_q <= '0;
      else       gray_s_q <= gray_s_d;
   end

   assign gray_s = gray_s_q;
`endif

   logic [GW-1:0] bin;
   assign bin = GW'(gray2bin(32'(gray_s), GW));

   // ---------------------------------------------------------------- tracker
   trk_state_t       state_q,    state_d;
   logic [GW-1:0]    prev_bin_q, prev_bin_d;
   logic [PW-1:0]    pos_q,      pos_d;
   logic             step_up_q,  step_up_d;
   logic             step_dn_q,  step_dn_d;
   logic             dir_q,      dir_d;
   logic             valid_q,    valid_d;
   logic             err_q,      err_d;
   logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
   logic [GW-1:0]    delta;

   // Modular difference makes the 100<->000 wrap an ordinary +1/-1 step.
   assign delta = bin - prev_bin_q;

   always_comb begin
      state_d    = state_q;
      prev_bin_d = prev_bin_q;
      pos_d      = pos_q;
      step_up_d  = 1'b0;
      step_dn_d  = 1'b0;
      dir_d      = dir_q;
      valid_d    = valid_q;
      err_d      = err_q;
      err_cnt_d  = err_cnt_q;

      if (clr) begin
         // dir and prev_bin are held; the next enabled cycle rebaselines anyway.
         state_d   = S_INIT;
         pos_d     = '0;
         valid_d   = 1'b0;
         err_d     = 1'b0;
         err_cnt_d = '0;
      end else if (en) begin
         unique case (state_q)
            S_INIT: begin
               prev_bin_d = bin;
               valid_d    = 1'b1;
               state_d    = S_TRACK;
            end
            S_TRACK: begin
               // Baseline always follows the input so an illegal jump resyncs.
               prev_bin_d = bin;
               if (delta == DELTA_UP) begin
                  pos_d     = pos_q + PW'(1);
                  step_up_d = 1'b1;
                  dir_d     = 1'b1;
               end else if (delta == DELTA_DN) begin
                  pos_d     = pos_q - PW'(1);
                  step_dn_d = 1'b1;
                  dir_d     = 1'b0;
               end else if (delta != '0) begin
                  err_d = 1'b1;
                  if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
               end
            end
            default: state_d = S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_INIT;
         prev_bin_q <= '0;
         pos_q      <= '0;
         step_up_q  <= 1'b0;
         step_dn_q  <= 1'b0;
         dir_q      <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         prev_bin_q <= prev_bin_d;
         pos_q      <= pos_d;
         step_up_q  <= step_up_d;
         step_dn_q  <= step_dn_d;
         dir_q      <= dir_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign pos     = pos_q;
   assign step_up = step_up_q;
   assign step_dn = step_dn_q;
   assign dir     = dir_q;
   assign valid   = valid_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Bench for gray_pos_tracker: sequence-index model checked every cycle plus directed literal checks.
// Latency: model applies the same input-to-output delay as the selected build.
// Backpressure: n/a.
module tb_gray_pos_tracker;

`ifdef GRAY_TRK_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic [2:0]  gray_in = 3'b000;
   logic [15:0] pos;
   logic        step_up, step_dn, dir, valid, err;
   logic [7:0]  err_cnt;

   gray_pos_tracker dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .clr     (clr),
      .gray_in (gray_in),
      .pos     (pos),
      .step_up (step_up),
      .step_dn (step_dn),
      .dir     (dir),
      .valid   (valid),
      .err     (err),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_up_seen = 0;
   int n_dn_seen = 0;

   // Reflected Gray sequence and its inverse (Gray code -> position in sequence).
   logic [2:0] seq [8];
   int         idx_of [8];
   int         cur;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int          m_state, m_prev;
   logic [15:0] m_pos;
   logic        m_up, m_dn, m_dir, m_valid, m_err;
   int          m_cnt;
   logic [2:0]  hist1, hist2;

   initial begin
      logic [2:0] g;
      int p, d;
      m_state = 0; m_prev = 0; m_pos = '0; m_up = 0; m_dn = 0; m_dir = 0;
      m_valid = 0; m_err = 0; m_cnt = 0; hist1 = '0; hist2 = '0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_state = 0; m_prev = 0; m_pos = '0; m_up = 0; m_dn = 0; m_dir = 0;
            m_valid = 0; m_err = 0; m_cnt = 0; hist1 = '0; hist2 = '0;
         end else begin
            g = (LAT == 2) ? hist2 : hist1;
            hist2 = hist1;
            hist1 = gray_in;
            m_up = 0;
            m_dn = 0;
            if (clr) begin
               m_pos = '0; m_err = 0; m_cnt = 0; m_valid = 0; m_state = 0;
            end else if (en) begin
               p = idx_of[g];
               if (m_state == 0) begin
                  m_prev = p; m_valid = 1; m_state = 1;
               end else begin
                  d = (p - m_prev + 8) % 8;
                  if (d == 1) begin
                     m_pos = m_pos + 16'd1; m_up = 1; m_dir = 1;
                  end else if (d == 7) begin
                     m_pos = m_pos - 16'd1; m_dn = 1; m_dir = 0;
                  end else if (d != 0) begin
                     m_err = 1;
                     if (m_cnt < 255) m_cnt = m_cnt + 1;
                  end
                  m_prev = p;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- compare
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            chk("pos",     32'(pos),     32'(m_pos));
            chk("step_up", 32'(step_up), 32'(m_up));
            chk("step_dn", 32'(step_dn), 32'(m_dn));
            chk("dir",     32'(dir),     32'(m_dir));
            chk("valid",   32'(valid),   32'(m_valid));
            chk("err",     32'(err),     32'(m_err));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (step_up) n_up_seen++;
            if (step_dn) n_dn_seen++;
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go(input int i, input int hold);
      @(negedge clk);
      cur = i;
      gray_in = seq[cur];
      tick(hold);
   endtask

   initial begin
      int up0, dn0;
      seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b010;
      seq[4] = 3'b110; seq[5] = 3'b111; seq[6] = 3'b101; seq[7] = 3'b100;
      for (int i = 0; i < 8; i++) idx_of[seq[i]] = i;
      cur = 0;

      // Reset state
      tick(3);
      reset = 1'b0;
      #1;
      chk("rst_pos", 32'(pos), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_steps", 32'({step_up, step_dn, dir, err}), 32'h0);
      chk("rst_err_cnt", 32'(err_cnt), 32'h0);

      // 1. Baseline
      en = 1'b1;
      tick(LAT + 2);
      chk("t1_valid", 32'(valid), 32'h1);
      chk("t1_pos", 32'(pos), 32'h0);
      chk("t1_no_steps", 32'(n_up_seen + n_dn_seen), 32'h0);

      // 2. Count up 000->001->011->010
      up0 = n_up_seen;
      go(1, 4); go(2, 4); go(3, 4);
      chk("t2_pos", 32'(pos), 32'h3);
      chk("t2_dir", 32'(dir), 32'h1);
      chk("t2_ups", 32'(n_up_seen - up0), 32'h3);

      // 3. Rebaseline at 100, then wrap up and back down
      @(negedge clk); en = 1'b0; clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      go(7, LAT + 2);
      en = 1'b1;
      tick(2);
      chk("t3_valid", 32'(valid), 32'h1);
      chk("t3_base_pos", 32'(pos), 32'h0);
      up0 = n_up_seen; dn0 = n_dn_seen;
      go(0, LAT + 2);
      chk("t3_wrap_up", 32'(pos), 32'h1);
      chk("t3_up_pulse", 32'(n_up_seen - up0), 32'h1);
      go(7, LAT + 2);
      chk("t3_wrap_dn", 32'(pos), 32'h0);
      chk("t3_dn_pulse", 32'(n_dn_seen - dn0), 32'h1);
      chk("t3_dir", 32'(dir), 32'h0);

      // 4. Illegal jump 000->010, then legal 010->110
      go(0, LAT + 2);
      chk("t4_pre_pos", 32'(pos), 32'h1);
      go(3, LAT + 2);
      chk("t4_err", 32'(err), 32'h1);
      chk("t4_err_cnt", 32'(err_cnt), 32'h1);
      chk("t4_pos_held", 32'(pos), 32'h1);
      go(4, LAT + 2);
      chk("t4_resync_pos", 32'(pos), 32'h2);

      // 5. Walk up to 0x7FFF, cross to 0x8000 and back
      for (int i = 0; i < 32765; i++) begin
         @(negedge clk);
         cur = (cur + 1) % 8;
         gray_in = seq[cur];
      end
      tick(LAT + 2);
      chk("t5_pos_max", 32'(pos), 32'h7FFF);
      go((cur + 1) % 8, LAT + 2);
      chk("t5_pos_wrap", 32'(pos), 32'h8000);
      go((cur + 7) % 8, LAT + 2);
      chk("t5_pos_unwrap", 32'(pos), 32'h7FFF);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cur = (cur + 3) % 8;
         gray_in = seq[cur];
      end
      tick(LAT + 2);
      chk("t5_err_sat", 32'(err_cnt), 32'hFF);
      chk("t5_pos_after_err", 32'(pos), 32'h7FFF);

      // 6. clr in the same cycle as a pending +1 step
      up0 = n_up_seen;
      @(negedge clk);
      cur = (cur + 1) % 8;
      gray_in = seq[cur];
      tick(LAT);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("t6_pos", 32'(pos), 32'h0);
      chk("t6_valid", 32'(valid), 32'h0);
      chk("t6_err", 32'({err, err_cnt}), 32'h0);
      chk("t6_no_pulse", 32'(n_up_seen - up0), 32'h0);
      chk("t6_dir_held", 32'(dir), 32'h0);
      tick(2);
      chk("t6_rebase_valid", 32'(valid), 32'h1);
      chk("t6_rebase_pos", 32'(pos), 32'h0);
      go((cur + 1) % 8, LAT + 2);
      chk("t6_step_pos", 32'(pos), 32'h1);

      // 7. Asynchronous reset mid-operation
      go((cur + 1) % 8, LAT + 2);
      #2;
      reset = 1'b1;
      #1;
      chk("t7_async_pos", 32'(pos), 32'h0);
      chk("t7_async_valid", 32'(valid), 32'h0);
      chk("t7_async_dir", 32'(dir), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
